// File: rtl/rv32im_dmem_responder_pkg.sv
// Shared types and constants for the rv32im data-memory responder.
package rv32im_dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } dmem_state_e;

    localparam logic [3:0] MaskNone  = 4'b0000;
    localparam logic [3:0] MaskByte0 = 4'b0001;
    localparam logic [3:0] MaskByte1 = 4'b0010;
    localparam logic [3:0] MaskByte2 = 4'b0100;
    localparam logic [3:0] MaskByte3 = 4'b1000;
    localparam logic [3:0] MaskHalf0 = 4'b0011;
    localparam logic [3:0] MaskHalf1 = 4'b1100;
    localparam logic [3:0] MaskWord  = 4'b1111;

    function automatic logic mask_is_legal(input logic [3:0] m);
        case (m)
            MaskNone, MaskByte0, MaskByte1, MaskByte2, MaskByte3,
            MaskHalf0, MaskHalf1, MaskWord: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32im_dmem_array.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module rv32im_dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rv32im_dmem_responder.sv
// Load/store responder: captures one request, waits WAIT_STATES cycles, then
// accesses the RAM and returns a one-cycle valid strobe while stalling the core.
module rv32im_dmem_responder
    import rv32im_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_enable_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wr_mask_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_valid_o,
    output logic        mem_err_o,
    output logic        mem_stall_o
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] Span  = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WsCnt = 4'(WAIT_STATES);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic        err_q, rd_ok_q;
    logic        go_resp;

    logic [31:0]   cur_addr, cur_wdata, offset;
    logic [3:0]    cur_mask, ram_we;
    logic          legal;
    logic [AW-1:0] idx;
    logic [31:0]   ram_rdata;

    // With zero wait states the RAM is accessed on the capture edge, so use live inputs in IDLE.
    always_comb begin
        cur_addr  = (state_q == StIdle) ? mem_addr_i    : addr_q;
        cur_wdata = (state_q == StIdle) ? mem_wdata_i   : wdata_q;
        cur_mask  = (state_q == StIdle) ? mem_wr_mask_i : mask_q;
        offset    = cur_addr - BASE_ADDR;
        idx       = offset[AW+1:2];
        legal     = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < Span) && mask_is_legal(cur_mask);
        ram_we    = (go_resp && legal) ? cur_mask : MaskNone;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_enable_i) begin
                    cnt_d = WsCnt;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        go_resp = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    go_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && mem_enable_i) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                mask_q  <= mem_wr_mask_i;
            end
            if (go_resp) begin
                err_q   <= ~legal;
                rd_ok_q <= legal && (cur_mask == MaskNone);
            end
        end
    end

    rv32im_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk_i),
        .en    (go_resp),
        .we    (ram_we),
        .addr  (idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; gating keeps rdata zero after reset, writes and errors.
    assign mem_rdata_o = rd_ok_q ? ram_rdata : 32'd0;
    assign mem_valid_o = (state_q == StResp);
    assign mem_err_o   = mem_valid_o & err_q;
    assign mem_stall_o = mem_enable_i & (state_q != StResp);

endmodule

// File: tb/tb_rv32im_dmem_responder.sv
// Bench for rv32im_dmem_responder: three instances with WAIT_STATES 0, 1 and 3.
module tb_rv32im_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  mask  [3];
    logic [31:0] rdata [3];
    logic        valid [3];
    logic        err   [3];
    logic        stall [3];

    int ws_of [3] = '{0, 1, 3};

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rv32im_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_ws0 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[0]), .mem_addr_i(addr[0]),
        .mem_wdata_i(wdata[0]), .mem_wr_mask_i(mask[0]), .mem_rdata_o(rdata[0]),
        .mem_valid_o(valid[0]), .mem_err_o(err[0]), .mem_stall_o(stall[0])
    );

    rv32im_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_ws1 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[1]), .mem_addr_i(addr[1]),
        .mem_wdata_i(wdata[1]), .mem_wr_mask_i(mask[1]), .mem_rdata_o(rdata[1]),
        .mem_valid_o(valid[1]), .mem_err_o(err[1]), .mem_stall_o(stall[1])
    );

    rv32im_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut_ws3 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[2]), .mem_addr_i(addr[2]),
        .mem_wdata_i(wdata[2]), .mem_wr_mask_i(mask[2]), .mem_rdata_o(rdata[2]),
        .mem_valid_o(valid[2]), .mem_err_o(err[2]), .mem_stall_o(stall[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issues one request on instance s; b2b means it follows a response with no idle gap.
    task automatic do_req(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [31:0] erd, input logic eer,
                          input bit b2b);
        exp_t e;
        int   k;
        int   stalls;
        bit   got;
        e.rd = erd;
        e.er = eer;
        sb.push_back(e);
        en[s]    = 1'b1;
        addr[s]  = a;
        wdata[s] = d;
        mask[s]  = m;
        #1;
        stalls = stall[s] ? 1 : 0;
        k      = 0;
        got    = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (valid[s]) begin
                got = 1'b1;
                check("stall_in_resp", 32'(stall[s]), 32'd0);
            end else if (stall[s]) begin
                stalls++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no valid from instance %0d for addr %h, want valid", s, a);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check("rdata", rdata[s], e.rd);
            check("err", 32'(err[s]), 32'(e.er));
            check("latency", 32'(k), 32'(b2b ? ws_of[s] + 2 : ws_of[s] + 1));
            check("stall_cycles", 32'(stalls), 32'(ws_of[s] + 1));
        end
        @(negedge clk);
        en[s] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            en[s]    = 1'b0;
            addr[s]  = 32'd0;
            wdata[s] = 32'd0;
            mask[s]  = 4'd0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_valid", 32'(valid[s]), 32'd0);
            check("reset_err", 32'(err[s]), 32'd0);
            check("reset_rdata", rdata[s], 32'd0);
            check("reset_stall", 32'(stall[s]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Functional table on the WAIT_STATES=1 instance.
        vecs.push_back('{32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h20,       32'h11223344, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{32'h20,       32'hAA000000, 4'b1000, 32'h0,        1'b0});
        vecs.push_back('{32'h20,       32'h0,        4'b0000, 32'hAA223344, 1'b0});
        vecs.push_back('{32'h20,       32'h0000BEEF, 4'b0011, 32'h0,        1'b0});
        vecs.push_back('{32'h20,       32'h0,        4'b0000, 32'hAA22BEEF, 1'b0});
        vecs.push_back('{32'h1000,     32'h0,        4'b0000, 32'h0,        1'b1});
        vecs.push_back('{32'h20,       32'hFFFFFFFF, 4'b0101, 32'h0,        1'b1});
        vecs.push_back('{32'h20,       32'h0,        4'b0000, 32'hAA22BEEF, 1'b0});
        vecs.push_back('{32'h24,       32'hCAFEF00D, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{32'h26,       32'h00770000, 4'b0100, 32'h0,        1'b0});
        vecs.push_back('{32'h24,       32'h0,        4'b0000, 32'hCA77F00D, 1'b0});
        vecs.push_back('{32'hFFC,      32'h12345678, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{32'hFFC,      32'h0,        4'b0000, 32'h12345678, 1'b0});
        vecs.push_back('{32'h20,       32'h0,        4'b0110, 32'h0,        1'b1});
        vecs.push_back('{32'hFFFFFFFC, 32'h87654321, 4'b1111, 32'h0,        1'b1});
        vecs.push_back('{32'h20,       32'h0,        4'b0000, 32'hAA22BEEF, 1'b0});
        foreach (vecs[i]) begin
            @(negedge clk);
            do_req(1, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].rd, vecs[i].er, 1'b0);
        end

        // Latency and back-to-back sweep across all three wait-state settings.
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            do_req(s, 32'h80, 32'h0BAD0000 + 32'(s), 4'b1111, 32'h0, 1'b0, 1'b0);
            do_req(s, 32'h80, 32'h0, 4'b0000, 32'h0BAD0000 + 32'(s), 1'b0, 1'b1);
            do_req(s, 32'h84, 32'h5EED0000, 4'b1111, 32'h0, 1'b0, 1'b1);
            do_req(s, 32'h84, 32'h0, 4'b0000, 32'h5EED0000, 1'b0, 1'b1);
        end

        // Reset while a write is still waiting on the WAIT_STATES=3 instance.
        @(negedge clk);
        do_req(2, 32'h40, 32'h11111111, 4'b1111, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        do_req(2, 32'h40, 32'h0, 4'b0000, 32'h11111111, 1'b0, 1'b0);
        @(negedge clk);
        en[2]    = 1'b1;
        addr[2]  = 32'h40;
        wdata[2] = 32'h55AA55AA;
        mask[2]  = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy_stall", 32'(stall[2]), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_valid", 32'(valid[2]), 32'd0);
        check("midreset_err", 32'(err[2]), 32'd0);
        check("midreset_rdata", rdata[2], 32'd0);
        @(negedge clk);
        en[2] = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        do_req(2, 32'h40, 32'h0, 4'b0000, 32'h11111111, 1'b0, 1'b0);

        // Ten idle cycles change nothing.
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("idle_stall", 32'(stall[1]), 32'd0);
            check("idle_valid", 32'(valid[1]), 32'd0);
            check("idle_err", 32'(err[1]), 32'd0);
        end
        @(negedge clk);
        do_req(1, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
        @(negedge clk);
        do_req(1, 32'h20, 32'h0, 4'b0000, 32'hAA22BEEF, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
